// File: rtl/nrisc_pkg.sv
// Shared nRisc datapath constants: address width, reset vector and PC run/halt encoding.
// Used by the program counter, instruction memory and branch unit.
package nrisc_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned RESET_ADDR = 0;

    typedef logic [ADDR_W-1:0] addr_t;

    // The PC has two states, carried directly by its halted flag.
    localparam logic [0:0] PC_RUN  = 1'b0;
    localparam logic [0:0] PC_HALT = 1'b1;

endpackage

// File: rtl/pc.sv
// nRisc program counter: loads the upstream next-address each cycle until Encerra
// freezes it; the halt is sticky and only an asynchronous reset clears it.
module pc
    import nrisc_pkg::*;
#(
    parameter int unsigned        WIDTH      = ADDR_W,
    parameter logic [WIDTH-1:0]   RESET_ADDR = WIDTH'(nrisc_pkg::RESET_ADDR)
) (
    input  logic             clock,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    input  logic             Encerra,
    input  logic             reset_n,
    output logic             halted
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [0:0]       halted_q;
    logic [0:0]       halted_d;

    // Halt wins over load: the address presented alongside Encerra is discarded.
    always_comb begin
        out_d    = out_q;
        halted_d = halted_q;
        if (halted_q == PC_RUN) begin
            if (Encerra) begin
                halted_d = PC_HALT;
            end else begin
                out_d = in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= RESET_ADDR;
            halted_q <= PC_RUN;
        end else begin
            out_q    <= out_d;
            halted_q <= halted_d;
        end
    end

    assign out    = out_q;
    assign halted = halted_q[0];

`ifdef PC_ASSERTIONS
    property p_frozen_while_halted;
        @(posedge clock) disable iff (!reset_n)
            halted |=> $stable(out);
    endproperty

    property p_halt_sticky;
        @(posedge clock) disable iff (!reset_n)
            halted |=> halted;
    endproperty

    a_frozen_while_halted : assert property (p_frozen_while_halted);
    a_halt_sticky         : assert property (p_halt_sticky);
`endif

endmodule

// File: tb/tb_pc.sv
// Bench for the nRisc program counter: directed literal checks followed by
// randomized load/halt/reset traffic checked every cycle against a behavioural model.
module tb_pc;

    logic       clock = 1'b0;
    logic [7:0] din;
    logic [7:0] dout;
    logic       enc;
    logic       reset_n;
    logic       halted;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 1'b0;
    bit done = 1'b0;

    // Behavioural model: what the PC must hold according to the rules.
    int unsigned m_pc = 0;
    bit          m_halted = 1'b0;

    pc #(.WIDTH(8), .RESET_ADDR(8'd0)) dut (
        .clock   (clock),
        .in      (din),
        .out     (dout),
        .Encerra (enc),
        .reset_n (reset_n),
        .halted  (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update and per-cycle comparison.
    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_pc = 0;
                m_halted = 1'b0;
            end else if (!m_halted) begin
                if (enc) m_halted = 1'b1;
                else     m_pc = din;
            end
            #1;
            if (check_en && !done) begin
                check("model_out", dout, m_pc);
                check("model_halted", halted, m_halted);
            end
        end
    end

    task automatic edge_check(input string name, input int unsigned exp_out, input bit exp_h);
        @(posedge clock);
        #2;
        check({name, "_out"}, dout, exp_out);
        check({name, "_halted"}, halted, exp_h);
    endtask

    initial begin
        reset_n = 1'b1;
        din = 8'd0;
        enc = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check_en = 1'b1;
        check("por_out", dout, 0);
        check("por_halted", halted, 0);

        // Load a nonzero value, then assert reset mid-cycle.
        @(negedge clock); reset_n = 1'b1; din = 8'h5A;
        edge_check("load5a", 8'h5A, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_out", dout, 0);
        check("async_rst_halted", halted, 0);

        @(negedge clock); reset_n = 1'b1; din = 8'd1;
        edge_check("load1", 1, 1'b0);
        @(negedge clock); din = 8'd0;
        edge_check("load0", 0, 1'b0);
        @(negedge clock); din = 8'd255;
        edge_check("load255", 255, 1'b0);
        @(negedge clock); din = 8'd0;
        edge_check("load0b", 0, 1'b0);
        @(negedge clock); din = 8'd1; enc = 1'b1;
        edge_check("halt", 0, 1'b1);
        @(negedge clock); din = 8'd5; enc = 1'b0;
        for (int i = 0; i < 3; i++) edge_check("held", 0, 1'b1);
        @(negedge clock); enc = 1'b1; din = 8'd77;
        edge_check("held_enc", 0, 1'b1);

        // Reset out of HALT, with a clock edge while reset is held.
        @(negedge clock); enc = 1'b0; din = 8'd9; reset_n = 1'b0;
        #1;
        check("halt_rst_out", dout, 0);
        check("halt_rst_halted", halted, 0);
        edge_check("rst_held", 0, 1'b0);
        @(negedge clock); reset_n = 1'b1; din = 8'd7;
        edge_check("load7", 7, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            din = 8'($urandom);
            enc = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 39) == 0) begin
                #2 reset_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clock);
                din = 8'($urandom);
                #1 reset_n = 1'b1;
            end
        end

        @(negedge clock);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
